// File: rtl/nios2_sysid_arbiter_pkg.sv
// Shared types and constants for the system-ID arbiter.
package nios2_sysid_arbiter_pkg;

  // Boot self-check runs ID then timestamp, then the block serves masters.
  typedef enum logic [1:0] {
    BOOT_ID = 2'd0,
    BOOT_TS = 2'd1,
    ARB     = 2'd2
  } state_e;

  // Word select values on the sysid slave address.
  localparam logic SYSID_ID_WORD = 1'b0;
  localparam logic SYSID_TS_WORD = 1'b1;

endpackage

// File: rtl/nios2_sysid_arbiter_if.sv
// Master-side Avalon-MM read ports plus the sysid slave port.
interface nios2_sysid_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_W      = 32
);
  logic [NUM_MASTERS-1:0]             m_read;
  logic [NUM_MASTERS-1:0]             m_address;
  logic [NUM_MASTERS-1:0]             m_waitrequest;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_readdata;
  logic [NUM_MASTERS-1:0]             m_readdatavalid;
  logic                               s_address;
  logic [DATA_W-1:0]                  s_readdata;

  // Arbiter view: slave to the masters, drives the sysid address.
  modport slave (
    input  m_read, m_address, s_readdata,
    output m_waitrequest, m_readdata, m_readdatavalid, s_address
  );

  // Environment view: the masters plus the sysid slave itself.
  modport master (
    output m_read, m_address, s_readdata,
    input  m_waitrequest, m_readdata, m_readdatavalid, s_address
  );
endinterface

// File: rtl/nios2_sysid_arbiter_rr.sv
// Combinational round-robin picker; the pointer register lives in the parent.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_vld
);

  // Scan from ptr upward (wrapping); first requester wins.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!gnt_vld && req[idx]) begin
        gnt_vld      = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/nios2_sysid_arbiter.sv
// Shares the sysid slave between NUM_MASTERS read-only masters and runs a
// boot/recheck self-check of the ID and timestamp words.
module nios2_sysid_arbiter
  import nios2_sysid_arbiter_pkg::*;
#(
  parameter int                NUM_MASTERS = 2,
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] EXPECTED_ID = '0,
  parameter logic [DATA_W-1:0] EXPECTED_TS = DATA_W'(1588802763)
) (
  input  logic                       clock,
  input  logic                       reset,
  nios2_sysid_arbiter_if.slave       bus,
  input  logic                       recheck,
  output logic                       check_done,
  output logic                       id_ok
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  state_e                             state_q, state_d;
  logic [PW-1:0]                      ptr_q, ptr_d;
  logic                               id_match_q, id_match_d;
  logic                               check_done_q, check_done_d;
  logic                               id_ok_q, id_ok_d;
  logic [NUM_MASTERS-1:0]             rdv_q, rdv_d;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] rdata_q, rdata_d;

  logic                   arb_en;
  logic [NUM_MASTERS-1:0] req, gnt;
  logic [PW-1:0]          gnt_idx;
  logic                   gnt_vld;

  // Grants only in ARB; a recheck cycle or reset masks every request so
  // waitrequest falls out as all-ones with no extra muxing.
  assign arb_en = (state_q == ARB) && !recheck && !reset;
  assign req    = bus.m_read & {NUM_MASTERS{arb_en}};

  rr_arbiter #(.N(NUM_MASTERS), .PW(PW)) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign bus.m_waitrequest   = ~gnt;
  assign bus.m_readdata      = rdata_q;
  assign bus.m_readdatavalid = rdv_q;
  assign check_done          = check_done_q;
  assign id_ok               = id_ok_q;

  // Slave address: fixed word during boot, the winner's word in ARB.
  always_comb begin
    bus.s_address = SYSID_ID_WORD;
    case (state_q)
      BOOT_ID: bus.s_address = SYSID_ID_WORD;
      BOOT_TS: bus.s_address = SYSID_TS_WORD;
      default: if (gnt_vld) bus.s_address = bus.m_address[gnt_idx];
    endcase
  end

  // Next-state, self-check results and one-cycle-latency read return.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_match_d   = id_match_q;
    check_done_d = check_done_q;
    id_ok_d      = id_ok_q;
    rdata_d      = rdata_q;
    rdv_d        = '0;
    case (state_q)
      BOOT_ID: begin
        id_match_d = (bus.s_readdata == EXPECTED_ID);
        state_d    = BOOT_TS;
      end
      BOOT_TS: begin
        id_ok_d      = id_match_q && (bus.s_readdata == EXPECTED_TS);
        check_done_d = 1'b1;
        state_d      = ARB;
      end
      ARB: begin
        if (recheck) begin
          state_d      = BOOT_ID;
          check_done_d = 1'b0;
        end
        if (gnt_vld) begin
          rdv_d            = gnt;
          rdata_d[gnt_idx] = bus.s_readdata;
          ptr_d            = (gnt_idx == PW'(NUM_MASTERS - 1)) ? '0 : PW'(gnt_idx + 1'b1);
        end
      end
      default: state_d = BOOT_ID;
    endcase
  end

  // State registers; reset drops any in-flight response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= BOOT_ID;
      ptr_q        <= '0;
      id_match_q   <= 1'b0;
      check_done_q <= 1'b0;
      id_ok_q      <= 1'b0;
      rdv_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_match_q   <= id_match_d;
      check_done_q <= check_done_d;
      id_ok_q      <= id_ok_d;
      rdv_q        <= rdv_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule
